rram_op_sequencer: RTL and testbench
====================================

# rram_op_sequencer

Sequences the RRAM state counter between three requesters: forming, write (cache to RRAM) and read (RRAM to cache). One request is granted at a time. The granted request's mode and enable are driven onto the state counter, and the block waits for that mode's count-complete flag. It then signals completion, or signals an error if a watchdog expires. It sits between the RRAM top-level control and the state counter, and is the only driver of the counter's `en`, `we`, `re` and `forming` inputs.

## Interface
Parameters:
- `TIMEOUT`, default 63: number of RUN cycles without the expected flag before error; range 1..255.
- `WD_W`, default 8: watchdog counter width; must satisfy TIMEOUT < 2^WD_W.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `form_req` / `write_req` / `read_req`  in  1 each  level requests; held high until `op_done` or `op_err`.
- `form_gnt` / `write_gnt` / `read_gnt`  out  1 each  one-hot grant; high for the whole operation.
- `op_done`  out  1  one-cycle pulse: the granted operation completed.
- `op_err`  out  1  one-cycle pulse: the granted operation timed out or was aborted.
- `busy`  out  1  high in every state except IDLE.
- `ctr_en` / `ctr_we` / `ctr_re` / `ctr_forming`  out  1 each  drive the state counter's `en`, `we`, `re` and `forming` inputs.
- `forming_count_flag` / `write_count_flag` / `cache_count_flag`  in  1 each  completion flags from the state counter.

## Operation
- States:
  - IDLE: no grant.
  - RUN: an operation is in progress.
  - DONE: completion; `op_done` high.
  - ERR: failure; `op_err` high.
- Reset (async, immediate, including mid-operation):
  - State is IDLE.
  - All outputs are 0, the watchdog is 0 and the arbiter pointer points at forming.
- IDLE: if any request is high, arbitrate (see Configuration) and register the winner.
  - Next state is RUN.
  - The winner's grant goes high, together with `ctr_en` and exactly one mode bit:
    - forming grant drives `ctr_forming`;
    - write grant drives `ctr_we`;
    - read grant drives `ctr_re`.
- RUN: the watchdog increments every cycle, starting from 0 on entry.
  - Only the flag that matches the active mode is sampled:
    - forming mode: `forming_count_flag`;
    - write mode: `write_count_flag`;
    - read mode: `cache_count_flag`.
  - Flags for other modes are ignored.
  - If the matching flag is high, go to DONE.
  - Else, if the watchdog equals TIMEOUT, go to ERR.
  - Else, if the granted request has dropped, go to ERR (abort).
- Simultaneous events in RUN: the matching flag wins over timeout and over abort.
- DONE and ERR each last exactly one cycle and then return to IDLE.
  - In both states the grant, `ctr_en` and the mode bits are already 0.
- Requests are never re-granted in the same cycle the previous operation finishes. There is at least one IDLE cycle between operations.
- Grants and mode bits are registered outputs: glitch-free and mutually exclusive.

## Timing
- Request high in IDLE at edge k: grant, `ctr_en` and the mode bit are high after edge k+1.
- Matching flag sampled high at edge n in RUN:
  - after edge n+1: grant and `ctr_en` low, `op_done` high;
  - after edge n+2: `op_done` low, back in IDLE;
  - earliest next grant is after edge n+3.
- A flag already high on the first RUN cycle completes the operation with 1 cycle of `ctr_en`.
- Timeout: `op_err` rises TIMEOUT+1 cycles after the grant rises, provided no flag arrives.
- `busy` equals (state != IDLE).

## Configuration
- `RRAM_SEQ_RR_EN` defined: round-robin arbitration.
  - The priority order rotates to start just after the last granted requester.
  - The pointer updates on every grant, including grants that end in ERR.
- `RRAM_SEQ_RR_EN` undefined: fixed priority, forming > write > read. The pointer logic is absent.

## Test plan
- Reset, then `write_req`=1 with `write_count_flag` pulsed 10 cycles after the grant:
  - `write_gnt`, `ctr_en` and `ctr_we` are high for 11 cycles;
  - `op_done` pulses once;
  - `ctr_re` and `ctr_forming` stay 0.
- All three requests held high, macro undefined:
  - grant order is forming, write, read, with each request dropped after its own done;
  - exactly one idle cycle between grants.
- All three requests held continuously, `RRAM_SEQ_RR_EN` defined: grant order is forming, write, read, forming, ...
- `read_req` held with no flag and TIMEOUT=63:
  - `op_err` pulses 64 cycles after `read_gnt` rises;
  - `read_gnt` then falls and `op_done` stays 0.
- In RUN, the matching flag and the watchdog reaching TIMEOUT in the same cycle: `op_done` pulses, `op_err` stays 0.
- `rst_n` driven low mid-RUN: all outputs go to 0 without waiting for a clock edge; after release the block stays in IDLE until a request arrives.

Source files
------------

// File: rtl/rram_op_sequencer.sv
// Grants one of forming / write / read to the RRAM state counter and waits for its count flag or a watchdog timeout.
// Build option: RRAM_SEQ_RR_EN selects round-robin arbitration; otherwise fixed priority forming > write > read.
module rram_op_sequencer #(
  parameter int TIMEOUT = 63,
  parameter int WD_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic form_req,
  input  logic write_req,
  input  logic read_req,
  output logic form_gnt,
  output logic write_gnt,
  output logic read_gnt,
  output logic op_done,
  output logic op_err,
  output logic busy,
  output logic ctr_en,
  output logic ctr_we,
  output logic ctr_re,
  output logic ctr_forming,
  input  logic forming_count_flag,
  input  logic write_count_flag,
  input  logic cache_count_flag
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_t          state_reg;
  logic [2:0]      gnt_reg;
  logic            ctr_en_reg;
  logic            op_done_reg;
  logic            op_err_reg;
  logic            busy_reg;
  logic [WD_W-1:0] wd_reg;

  // Bit order everywhere: [0] forming, [1] write, [2] read.
  logic [2:0] req_vec;
  logic [2:0] flag_vec;
  logic [2:0] hit_vec;
  logic [2:0] live_vec;
  logic [2:0] pick_next;

  assign req_vec  = {read_req, write_req, form_req};
  assign flag_vec = {cache_count_flag, write_count_flag, forming_count_flag};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mode
      assign hit_vec[gi]  = flag_vec[gi] & gnt_reg[gi];
      assign live_vec[gi] = req_vec[gi] & gnt_reg[gi];
    end
  endgenerate

`ifdef RRAM_SEQ_RR_EN
  // Pointer names the requester with highest priority for the next grant.
  logic [1:0] ptr_reg;

  always_comb begin
    pick_next = 3'b000;
    case (ptr_reg)
      2'd1: begin
        if (req_vec[1])      pick_next = 3'b010;
        else if (req_vec[2]) pick_next = 3'b100;
        else if (req_vec[0]) pick_next = 3'b001;
      end
      2'd2: begin
        if (req_vec[2])      pick_next = 3'b100;
        else if (req_vec[0]) pick_next = 3'b001;
        else if (req_vec[1]) pick_next = 3'b010;
      end
      default: begin
        if (req_vec[0])      pick_next = 3'b001;
        else if (req_vec[1]) pick_next = 3'b010;
        else if (req_vec[2]) pick_next = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 2'd0;
    end else if (state_reg == IDLE && (|req_vec)) begin
      if (pick_next[0])      ptr_reg <= 2'd1;
      else if (pick_next[1]) ptr_reg <= 2'd2;
      else                   ptr_reg <= 2'd0;
    end
  end
`else
  always_comb begin
    pick_next = 3'b000;
    if (req_vec[0])      pick_next = 3'b001;
    else if (req_vec[1]) pick_next = 3'b010;
    else if (req_vec[2]) pick_next = 3'b100;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= 3'b000;
      ctr_en_reg  <= 1'b0;
      op_done_reg <= 1'b0;
      op_err_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      wd_reg      <= '0;
    end else begin
      op_done_reg <= 1'b0;
      op_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          wd_reg <= '0;
          if (|req_vec) begin
            state_reg  <= RUN;
            gnt_reg    <= pick_next;
            ctr_en_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        RUN: begin
          wd_reg <= wd_reg + WD_W'(1);
          // Flag beats timeout and abort when they coincide.
          if (|hit_vec) begin
            state_reg   <= DONE;
            op_done_reg <= 1'b1;
            gnt_reg     <= 3'b000;
            ctr_en_reg  <= 1'b0;
          end else if (wd_reg == WD_LIMIT || !(|live_vec)) begin
            state_reg  <= ERR;
            op_err_reg <= 1'b1;
            gnt_reg    <= 3'b000;
            ctr_en_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          wd_reg    <= '0;
        end
      endcase
    end
  end

  assign form_gnt    = gnt_reg[0];
  assign write_gnt   = gnt_reg[1];
  assign read_gnt    = gnt_reg[2];
  assign ctr_forming = gnt_reg[0];
  assign ctr_we      = gnt_reg[1];
  assign ctr_re      = gnt_reg[2];
  assign ctr_en      = ctr_en_reg;
  assign op_done     = op_done_reg;
  assign op_err      = op_err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Scoreboard bench for rram_op_sequencer: a transaction-level model predicts winner, outcome and length of each operation.
module tb_rram_op_sequencer;

  localparam int TIMEOUT = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic form_req, write_req, read_req;
  logic form_gnt, write_gnt, read_gnt;
  logic op_done, op_err, busy;
  logic ctr_en, ctr_we, ctr_re, ctr_forming;
  logic forming_count_flag, write_count_flag, cache_count_flag;

  rram_op_sequencer #(.TIMEOUT(TIMEOUT), .WD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .form_req(form_req), .write_req(write_req), .read_req(read_req),
    .form_gnt(form_gnt), .write_gnt(write_gnt), .read_gnt(read_gnt),
    .op_done(op_done), .op_err(op_err), .busy(busy),
    .ctr_en(ctr_en), .ctr_we(ctr_we), .ctr_re(ctr_re), .ctr_forming(ctr_forming),
    .forming_count_flag(forming_count_flag), .write_count_flag(write_count_flag),
    .cache_count_flag(cache_count_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int err;
    int en_cycles;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int model_ptr = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  // Requester index 0 forming, 1 write, 2 read.
  function automatic int arb(input logic [2:0] r);
`ifdef RRAM_SEQ_RR_EN
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (model_ptr + k) % 3;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [9:0] outs();
    return {form_gnt, write_gnt, read_gnt, op_done, op_err, busy, ctr_en, ctr_we, ctr_re, ctr_forming};
  endfunction

  task automatic set_req(input logic [2:0] r);
    {read_req, write_req, form_req} = r;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {cache_count_flag, write_count_flag, forming_count_flag} = f;
  endtask

  // kind 0: flag d cycles after grant; 1: no flag (timeout); 2: drop requests d cycles after grant.
  // keep 0: clear requests at the end; 1: keep them; 2: drop only the winner's request.
  task automatic do_op(input logic [2:0] r, input int kind, input int d, input int gap, input int keep);
    int w, c;
    logic [2:0] f;
    logic got;
    exp_t e;
    w = arb(r);
    model_ptr = (w + 1) % 3;
    e.id = w;
    e.err = (kind != 0) ? 1 : 0;
    e.en_cycles = (kind == 1) ? TIMEOUT + 1 : d + 1;
    e.gap = gap;
    exp_q.push_back(e);
    set_req(r);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = form_gnt | write_gnt | read_gnt;
    end
    if (!got) begin
      check("grant_rise", 0, 1);
      set_req(3'b000);
      set_flags(3'b000);
      return;
    end
    c = 0;
    while (1) begin
      f = 3'($urandom_range(0, 7));
      f[w] = (kind == 0 && c == d);
      set_flags(f);
      if (kind == 2 && c == d) set_req(3'b000);
      @(negedge clk);
      c++;
      if (op_done || op_err) break;
      if (c > TIMEOUT + 8) begin
        check("op_end", 0, 1);
        break;
      end
    end
    set_flags(3'b000);
    if (keep == 0) set_req(3'b000);
    else if (keep == 2) set_req({read_req, write_req, form_req} & ~(3'b001 << w));
  endtask

  // Monitor: measures each operation as seen on the outputs and compares against the queue.
  int en_cnt = 0, idle_cnt = 0, first_gap = -1, seen_id = -1, bad = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0; idle_cnt = 0; first_gap = -1; seen_id = -1; bad = 0;
    end else begin
      logic [2:0] g;
      int id;
      exp_t e;
      g = {read_gnt, write_gnt, form_gnt};
      if (!busy) idle_cnt++;
      if ({ctr_re, ctr_we, ctr_forming} != g) bad = 1;
      if (ctr_en != (g != 3'b000)) bad = 1;
      if (ctr_en) begin
        case (g)
          3'b001:  id = 0;
          3'b010:  id = 1;
          3'b100:  id = 2;
          default: id = 9;
        endcase
        if (en_cnt == 0) begin
          seen_id = id;
          first_gap = idle_cnt;
        end else if (id != seen_id) bad = 1;
        en_cnt++;
      end
      if (op_done || op_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("grant_id", seen_id, e.id);
          check("outcome", (op_done && op_err) ? 2 : (op_err ? 1 : 0), e.err);
          check("en_cycles", en_cnt, e.en_cycles);
          if (e.gap >= 0) check("idle_gap", first_gap, e.gap);
          check("mode_bits_bad", bad, 0);
        end
        en_cnt = 0; idle_cnt = 0; first_gap = -1; seen_id = -1; bad = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] cur;
    logic [9:0] act;
    int e_idle, p, kind, d;
    set_req(3'b000);
    set_flags(3'b000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'(outs()), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'b010, 0, 10, -1, 0);
    do_op(3'b100, 1, 0, 1, 0);
    do_op(3'b001, 0, TIMEOUT, 1, 0);
    do_op(3'b010, 0, 0, 1, 0);
    do_op(3'b100, 2, 3, 1, 0);

    cur = 3'b111;
    repeat (3) begin
      do_op(cur, 0, $urandom_range(0, 4), 1, 2);
      cur = {read_req, write_req, form_req};
    end

    repeat (6) do_op(3'b111, 0, $urandom_range(0, 3), 1, 1);
    set_req(3'b000);

    set_req(3'b100);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", int'(outs()), 0);
    set_req(3'b000);
    set_flags(3'b000);
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = '0;
    repeat (5) begin
      @(negedge clk);
      act = act | outs();
    end
    check("idle_after_reset", int'(act), 0);
    do_op(3'b111, 0, 2, -1, 0);

    for (int n = 0; n < 40; n++) begin
      e_idle = $urandom_range(0, 2);
      repeat (e_idle) @(negedge clk);
      p = $urandom_range(0, 9);
      if (p < 6) begin kind = 0; d = $urandom_range(0, 15); end
      else if (p < 8) begin kind = 2; d = $urandom_range(0, 10); end
      else if (p == 8) begin kind = 1; d = 0; end
      else begin kind = 0; d = TIMEOUT; end
      do_op(3'($urandom_range(1, 7)), kind, d, (e_idle < 1) ? 1 : e_idle, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
